alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width.
REQ-002 Parameter TAG_WIDTH, default 4: request tag width.
REQ-003 Parameter RSP_DEPTH, default 4: result FIFO entries, power of two, >=2.
REQ-004 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 flush  in  1  synchronous pipeline/FIFO discard.
REQ-006 req_valid  in  1 / req_ready  out  1  upstream handshake.
REQ-007 req_a, req_b  in  DATA_WIDTH  operands; req_op  in  alu_op_t  opcode; req_tag  in  TAG_WIDTH  request ID.
REQ-008 alu_valid_in  out  1; alu_a, alu_b  out  DATA_WIDTH; alu_op  out  alu_op_t; alu_flush  out  1: drive the 2-stage ALU.
REQ-009 alu_valid_out  in  1; alu_y  in  DATA_WIDTH: ALU result.
REQ-010 rsp_valid  out  1 / rsp_ready  in  1  downstream handshake; rsp_y  out  DATA_WIDTH; rsp_tag  out  TAG_WIDTH.
REQ-011 err_sync  out  1  sticky ALU/tag misalignment flag.

Function
REQ-012 Block SHALL issue requests to the ALU and reorder-free collect results with backpressure the ALU itself lacks.
REQ-013 req_ready SHALL = !flush && (fifo_count + inflight) < RSP_DEPTH, computed from registered state only; same-cycle pop SHALL NOT be credited.
REQ-014 inflight SHALL = number of set valid bits in a 2-stage tag delay line (0..2), matching ALU latency.
REQ-015 Accept (req_valid && req_ready) SHALL drive alu_valid_in=1 combinationally that cycle; alu_a/alu_b/alu_op SHALL pass req_a/req_b/req_op straight through.
REQ-016 On accept, req_tag SHALL enter tag stage 1 at the clock edge; stage 1 SHALL advance to stage 2 next edge.
REQ-017 alu_valid_out SHALL be expected exactly when tag stage 2 is valid; on valid_out, {alu_y, stage-2 tag} SHALL be pushed into the result FIFO at the next edge.
REQ-018 Latency: accept in cycle N -> rsp_valid earliest in cycle N+3 with empty FIFO.
REQ-019 Throughput: one accept per cycle sustained while rsp_ready=1 and credits permit (RSP_DEPTH>=4 sustains 1/cycle with 3-deep occupancy).
REQ-020 FIFO SHALL be first-word-fall-through: rsp_valid = !empty; rsp_y/rsp_tag = head entry; pop on rsp_valid && rsp_ready.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo RSP_DEPTH.
REQ-022 Push to a full FIFO SHALL be impossible by REQ-013; if alu_valid_out arrives with FIFO full, result SHALL be dropped and err_sync set.
REQ-023 alu_valid_out with stage-2 tag invalid, or stage-2 tag valid without alu_valid_out, SHALL set err_sync; err_sync clears only by reset.
REQ-024 flush SHALL drive alu_flush=1 combinationally the same cycle, force req_ready=0, clear both tag stages and empty the FIFO at the edge; any alu_valid_out during the flush cycle SHALL NOT be pushed and SHALL NOT set err_sync.
REQ-025 rsp_valid SHALL be 0 the cycle after flush; inputs sampled in the flush cycle SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously clear tag valids, FIFO pointers/count, err_sync; rsp_valid=0, rsp_y=0, rsp_tag=0, alu_valid_in=0.
REQ-027 After reset release with flush=0, req_ready SHALL be 1; reset mid-operation SHALL discard all in-flight and stored results.

Structure
REQ-028 alu_op_t and new constant ALU_LATENCY=2 SHALL live in package alu_defines.
REQ-029 Result storage SHALL be sub-module alu_rsp_fifo (params WIDTH, DEPTH; push/pop/full/empty/count).
REQ-030 Tag delay line length SHALL derive from ALU_LATENCY.

Verification
REQ-031 Single op: ADD a=5,b=7,tag=3 accepted cycle 0, rsp_ready=1 -> rsp_valid cycle 3, rsp_y=12, rsp_tag=3.
REQ-032 Stream 8 ops tags 0..7 back-to-back, rsp_ready=1 -> req_ready stays 1, responses in order, correct values (SUB 3-5 = 0xFFFFFFFE, SLL 1<<31 = 0x80000000).
REQ-033 rsp_ready=0, continuous req_valid -> exactly RSP_DEPTH accepts, req_ready=0 thereafter, no drops, err_sync=0; release rsp_ready -> all 4 drain in order.
REQ-034 Flush with 2 in flight and 2 stored -> alu_flush pulses same cycle, rsp_valid=0 next cycle, no later stale response, err_sync=0.
REQ-035 Inject alu_valid_out with empty tag pipe -> err_sync=1 next cycle and stays 1 until rst_n.
REQ-036 Assert rst_n=0 mid-stream -> outputs reset asynchronously; after release, first new request returns with its own tag only.

Source files
------------

// File: rtl/alu_defines.sv
// Shared ALU definitions: opcode encoding and pipeline latency.
// Imported by the issue controller and its result FIFO.
package alu_defines;

  localparam int ALU_LATENCY = 2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// First-word-fall-through result FIFO with synchronous flush.
// Head data reads as zero while empty so reset/flush leave quiet outputs.
module alu_rsp_fifo
  import alu_defines::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rp];

  // Pointers and occupancy; flush empties the queue at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/collect wrapper around a fixed-latency ALU without backpressure.
// Credits reserve FIFO space for every op in flight before it is issued.
module alu_issue_ctrl
  import alu_defines::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  alu_op_t               req_op,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  alu_valid_in,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output alu_op_t               alu_op,
  output logic                  alu_flush,
  input  logic                  alu_valid_out,
  input  logic [DATA_WIDTH-1:0] alu_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_y,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  err_sync
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int FW = DATA_WIDTH + TAG_WIDTH;
  localparam int LN = ALU_LATENCY;

  logic [LN-1:0]                tv;
  logic [LN-1:0][TAG_WIDTH-1:0] tq;
  logic                         s2v;
  logic [TAG_WIDTH-1:0]         s2t;
  logic [CW-1:0]                inflight;
  logic [CW-1:0]                cnt;
  logic [CW:0]                  credit;
  logic                         accept;
  logic                         push;
  logic                         pop;
  logic                         full;
  logic                         empty;
  logic                         err_set;
  logic [FW-1:0]                head;

  assign s2v = tv[LN-1];
  assign s2t = tq[LN-1];

  // Count ops still inside the ALU pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LN; i++) begin
      inflight = inflight + CW'(tv[i]);
    end
  end

  assign credit    = {1'b0, cnt} + {1'b0, inflight};
  assign req_ready = rst_n && !flush
                  && (credit < (CW+1)'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  assign alu_valid_in = accept;
  assign alu_a        = req_a;
  assign alu_b        = req_b;
  assign alu_op       = req_op;
  assign alu_flush    = flush;

  assign push = !flush && alu_valid_out && s2v && !full;
  assign pop  = rsp_valid && rsp_ready;

  assign err_set = !flush
                && ((alu_valid_out != s2v)
                 || (alu_valid_out && s2v && full));

  // Tag delay line tracking each issued op through the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv <= '0;
      tq <= '0;
    end else if (flush) begin
      tv <= '0;
    end else begin
      tv[0] <= accept;
      tq[0] <= req_tag;
      for (int i = 1; i < LN; i++) begin
        tv[i] <= tv[i-1];
        tq[i] <= tq[i-1];
      end
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sync <= 1'b0;
    end else if (err_set) begin
      err_sync <= 1'b1;
    end
  end

  alu_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({alu_y, s2t}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  assign rsp_valid = !empty;
  assign rsp_y     = head[FW-1:TAG_WIDTH];
  assign rsp_tag   = head[TAG_WIDTH-1:0];

endmodule
